// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the pipelined CPU front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEFAULT_ADDR_W  = 64;
    localparam int DEFAULT_INSTR_W = 32;

    localparam int          PC_INCR   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_hold_buffer
//  Description : One-entry skid buffer for a fetched {instr, pc} pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buffer #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    // Clear wins over load so a squash never leaves a wrong-path entry behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : fetch_hold_buffer
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: PC, imem request/response and IF/DEC reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               stall_d,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic               valid_d
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_reqAddr;
    logic               r_validD;
    logic [INSTR_W-1:0] r_instrD;
    logic [ADDR_W-1:0]  r_pcD;

    logic               w_holdValid;
    logic [INSTR_W-1:0] w_holdInstr;
    logic [ADDR_W-1:0]  w_holdPc;

    logic               w_reqValid;
    logic               w_reqFire;
    logic               w_respFire;
    logic               w_redirect;
    logic               w_respToIfd;
    logic               w_holdLoad;
    logic               w_holdDrain;
    logic [ADDR_W-1:0]  w_target;

    // No new request while the skid entry is occupied; it must drain first.
    assign w_reqValid  = (r_state == REQ) && !w_holdValid && !reset;
    assign w_reqFire   = w_reqValid && imem_req_ready;
    assign w_respFire  = imem_resp_valid && (r_state == WAIT);
    assign w_redirect  = br_taken && r_validD && !stall_d;
    assign w_target    = br_target & ~ADDR_W'(3);

    assign w_respToIfd = w_respFire && !w_redirect && (!r_validD || !stall_d);
    assign w_holdLoad  = w_respFire && r_validD && stall_d;
    assign w_holdDrain = w_holdValid && !stall_d;

    fetch_hold_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_holdBuffer (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_holdLoad),
        .i_drain (w_holdDrain),
        .i_clear (w_redirect),
        .i_instr (imem_resp_data),
        .i_pc    (r_reqAddr),
        .o_valid (w_holdValid),
        .o_instr (w_holdInstr),
        .o_pc    (w_holdPc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= REQ;
            r_pc      <= RESET_PC;
            r_reqAddr <= '0;
            r_validD  <= 1'b0;
            r_instrD  <= INSTR_W'(NOP_INSTR);
            r_pcD     <= '0;
        end else begin
            if (w_reqFire) begin
                r_reqAddr <= r_pc;
            end

            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_reqFire) begin
                r_pc <= r_pc + ADDR_W'(PC_INCR);
            end

            // A redirect turns any in-flight request into a stale one to drop.
            case (r_state)
                REQ: begin
                    if (w_reqFire) begin
                        r_state <= w_redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        r_state <= REQ;
                    end else if (w_redirect) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_resp_valid) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase

            if (w_redirect) begin
                r_validD <= 1'b0;
            end else if (w_holdDrain) begin
                r_validD <= 1'b1;
                r_instrD <= w_holdInstr;
                r_pcD    <= w_holdPc;
            end else if (w_respToIfd) begin
                r_validD <= 1'b1;
                r_instrD <= imem_resp_data;
                r_pcD    <= r_reqAddr;
            end else if (!stall_d) begin
                r_validD <= 1'b0;
            end
        end
    end

    assign imem_req_valid = w_reqValid;
    assign imem_req_addr  = r_pc;
    assign instr_d        = r_instrD;
    assign pc_d           = r_pcD;
    assign valid_d        = r_validD;

endmodule : fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. It owns the PC register and the IF/DEC pipeline register.
- Drives a variable-latency instruction-memory request/response interface and delivers {instruction, PC, valid} to decode.
- Honours decode stalls and redirects the PC on branches resolved in decode (accelerated branching), squashing wrong-path fetches.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
ADDR_W, 64, PC/address width
INSTR_W, 32, instruction width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address (word aligned)
imem_resp_valid  input  1  response data valid
imem_resp_data  input  INSTR_W  fetched instruction
stall_d  input  1  decode holds IF/DEC register
br_taken  input  1  branch taken, resolved in decode
br_target  input  ADDR_W  branch target address
instr_d  output  INSTR_W  IF/DEC instruction
pc_d  output  ADDR_W  IF/DEC PC
valid_d  output  1  IF/DEC holds a real instruction

Behaviour:
- Reset is synchronous and active-high, on clk.
- Reset values: pc=RESET_PC, state=REQ, valid_d=0, instr_d=0, pc_d=0, hold buffer empty, imem_req_valid=0 during the reset cycle.
- Responses arriving in a reset cycle are ignored. Memory shares the same reset.
- States:
  - REQ: issuing a request.
  - WAIT: one request outstanding.
  - DROP: one outstanding request is stale.
- At most one outstanding request. Response arrives ≥1 cycle after acceptance. Peak throughput is 1 instruction per 2 cycles.
- REQ:
  - imem_req_valid=1 iff the hold buffer is empty. imem_req_addr=pc.
  - addr must stay stable while valid&!ready, unless redirected.
  - On valid&ready: pc<=pc+4, go to WAIT.
- WAIT, on imem_resp_valid:
  - If IF/DEC can accept (valid_d==0 or stall_d==0): load {instr_d, pc_d}=resp and its request address, valid_d<=1.
  - Else write {data, addr} into the hold buffer.
  - Go to REQ in either case.
- IF/DEC update when stall_d==0:
  - Priority: hold buffer → IF/DEC (buffer empties); else arriving response; else valid_d<=0 (bubble).
- IF/DEC when stall_d==1: all IF/DEC outputs held.
- Redirect fires when br_taken&valid_d&!stall_d; otherwise br_taken is ignored. On redirect:
  - pc<=br_target with bits[1:0] forced to 0.
  - valid_d<=0 next cycle; the sequential successor is squashed.
  - Hold buffer cleared.
  - Any same-cycle response is discarded.
- Redirect by state:
  - In REQ without handshake: the unaccepted request is withdrawn; the new address is presented next cycle.
  - In REQ with a same-cycle handshake: go to DROP.
  - In WAIT without a same-cycle response: go to DROP.
  - In WAIT with a same-cycle response: discard it, go to REQ.
- DROP:
  - imem_req_valid=0.
  - On imem_resp_valid: discard, go to REQ.
  - A further redirect in DROP updates pc and stays in DROP.
- PC arithmetic wraps modulo 2^ADDR_W (64'hFFFF_FFFF_FFFF_FFFC+4 → 0).
- Stall and response in the same cycle with valid_d=1: the response goes to the hold buffer; no new request until it drains.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}
  - PC_INCR=4
  - NOP_INSTR=32'h0
  - ADDR_W/INSTR_W defaults
- One sub-module: fetch_hold_buffer, a 1-entry skid buffer {valid, instr, pc} with load/drain/clear.

Test Plan:
- Reset then free run, memory latency 1, ready=1, stall_d=0 → request addresses 0,4,8; instr_d/pc_d sequence (mem[0],0),(mem[4],4),(mem[8],8), each valid_d pulse 2 cycles apart.
- imem_req_ready held 0 for 3 cycles at addr 8 → addr stays 8, pc stays 8, valid_d=0 bubbles, then normal resume.
- stall_d=1 for 4 cycles while response for addr 12 arrives → instr_d holds addr-8 instruction, addr-12 instruction in buffer, no new request; after release addr 12 appears next cycle, then request addr 16.
- br_taken=1, br_target=64'h103 with valid_d=1, response for addr 16 pending (latency 3) → state DROP, addr-16 data discarded, next request addr 64'h100, valid_d=0 until mem[0x100] delivered.
- br_taken=1 with stall_d=1 → ignored; br_taken=1 with valid_d=0 → ignored; sequential fetch continues.
- reset asserted in WAIT with a response arriving the same cycle → response ignored, valid_d=0, next request addr RESET_PC.
